// File: rtl/muldiv_ctrl_if.sv
// +-----------------------------------------------------------------------+
// | muldiv_ctrl_if : pipeline- and unit-side signals of the HI/LO control |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface muldiv_ctrl_if;
  logic        issue_valid;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [5:0]  mul_sig;
  logic [5:0]  div_sig;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic [63:0] mul_result;
  logic [63:0] div_result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;
  logic        busy;
  logic        stall;

  modport slave (
    input  issue_valid, funct, rs_data, rt_data, mul_result, div_result,
    output mul_sig, div_sig, unit_a, unit_b, hi, lo, mf_data, busy, stall
  );

  modport master (
    output issue_valid, funct, rs_data, rt_data, mul_result, div_result,
    input  mul_sig, div_sig, unit_a, unit_b, hi, lo, mf_data, busy, stall
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// +-----------------------------------------------------------------------+
// | muldiv_ctrl : sequences the iterative MULTU/DIVU units, owns HI/LO    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module muldiv_ctrl #(
  parameter int         MUL_CYCLES = 33,
  parameter int         DIV_CYCLES = 33,
  parameter logic [5:0] F_MULTU    = 6'b011001,
  parameter logic [5:0] F_DIVU     = 6'b011011,
  parameter logic [5:0] F_MFHI     = 6'b010000,
  parameter logic [5:0] F_MFLO     = 6'b010010
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic               r_sel_div, w_sel_div_nx;
  logic [5:0]         r_mul_sig, w_mul_sig_nx;
  logic [5:0]         r_div_sig, w_div_sig_nx;
  logic [31:0]        r_unit_a, w_unit_a_nx;
  logic [31:0]        r_unit_b, w_unit_b_nx;
  logic [31:0]        r_hi, w_hi_nx;
  logic [31:0]        r_lo, w_lo_nx;

  logic w_is_multu, w_is_divu, w_is_mfhi, w_is_mflo, w_hl_op, w_busy;

  assign w_is_multu = bus.issue_valid && (bus.funct == F_MULTU);
  assign w_is_divu  = bus.issue_valid && (bus.funct == F_DIVU);
  assign w_is_mfhi  = bus.issue_valid && (bus.funct == F_MFHI);
  assign w_is_mflo  = bus.issue_valid && (bus.funct == F_MFLO);
  assign w_hl_op    = w_is_multu || w_is_divu || w_is_mfhi || w_is_mflo;
  assign w_busy     = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sel_div <= 1'b0;
      r_mul_sig <= '0;
      r_div_sig <= '0;
      r_unit_a  <= '0;
      r_unit_b  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_sel_div <= w_sel_div_nx;
      r_mul_sig <= w_mul_sig_nx;
      r_div_sig <= w_div_sig_nx;
      r_unit_a  <= w_unit_a_nx;
      r_unit_b  <= w_unit_b_nx;
      r_hi      <= w_hi_nx;
      r_lo      <= w_lo_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_sel_div_nx = r_sel_div;
    w_mul_sig_nx = '0;
    w_div_sig_nx = '0;
    w_unit_a_nx  = r_unit_a;
    w_unit_b_nx  = r_unit_b;
    w_hi_nx      = r_hi;
    w_lo_nx      = r_lo;
    case (r_state)
      S_IDLE: begin
        if (w_is_multu) begin
          w_unit_a_nx  = bus.rs_data;
          w_unit_b_nx  = bus.rt_data;
          w_cnt_nx     = CNT_W'(MUL_CYCLES);
          w_mul_sig_nx = F_MULTU;
          w_sel_div_nx = 1'b0;
          w_state_nx   = S_MUL_RUN;
        end else if (w_is_divu && (bus.rt_data != 32'd0)) begin
          w_unit_a_nx  = bus.rs_data;
          w_unit_b_nx  = bus.rt_data;
          w_cnt_nx     = CNT_W'(DIV_CYCLES);
          w_div_sig_nx = F_DIVU;
          w_sel_div_nx = 1'b1;
          w_state_nx   = S_DIV_RUN;
        end else if (w_is_divu) begin
          // Divide by zero resolves immediately without touching the divider.
          w_hi_nx = bus.rs_data;
          w_lo_nx = 32'hFFFF_FFFF;
        end
      end
      S_MUL_RUN, S_DIV_RUN: begin
        w_cnt_nx = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nx = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        {w_hi_nx, w_lo_nx} = r_sel_div ? bus.div_result : bus.mul_result;
        w_state_nx         = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign bus.mul_sig = r_mul_sig;
  assign bus.div_sig = r_div_sig;
  assign bus.unit_a  = r_unit_a;
  assign bus.unit_b  = r_unit_b;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.busy    = w_busy;
  assign bus.stall   = w_hl_op && w_busy;
  assign bus.mf_data = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : 32'd0);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_muldiv_ctrl : directed vector bench with cycle-accurate unit models |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_ctrl;
  localparam logic [5:0] F_MULTU  = 6'b011001;
  localparam logic [5:0] F_DIVU   = 6'b011011;
  localparam logic [5:0] F_MFHI   = 6'b010000;
  localparam logic [5:0] F_MFLO   = 6'b010010;
  localparam logic [5:0] F_MULT   = 6'b011000;
  localparam logic [5:0] F_ADDU   = 6'b100001;
  localparam logic [5:0] UNIT_LAT = 6'd33;
  localparam int         RUN_BUSY = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(
    .MUL_CYCLES(33), .DIV_CYCLES(33),
    .F_MULTU(F_MULTU), .F_DIVU(F_DIVU), .F_MFHI(F_MFHI), .F_MFLO(F_MFLO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Unit models: dataOut is garbage until exactly UNIT_LAT edges after the start pulse.
  logic [5:0]  mcnt = '0, dcnt = '0;
  logic [63:0] mres = '0, dres = '0;
  always @(posedge clk) begin
    if (bus.mul_sig == F_MULTU) begin
      mcnt <= 6'd1;
      mres <= {32'd0, bus.unit_a} * {32'd0, bus.unit_b};
    end else if (mcnt != 6'd0 && mcnt < UNIT_LAT) begin
      mcnt <= mcnt + 6'd1;
    end
    if (bus.div_sig == F_DIVU) begin
      dcnt <= 6'd1;
      if (bus.unit_b != 32'd0) dres <= {bus.unit_a % bus.unit_b, bus.unit_a / bus.unit_b};
    end else if (dcnt != 6'd0 && dcnt < UNIT_LAT) begin
      dcnt <= dcnt + 6'd1;
    end
  end
  assign bus.mul_result = (mcnt == UNIT_LAT) ? mres : 64'hBAD0_BAD0_BAD0_BAD0;
  assign bus.div_result = (dcnt == UNIT_LAT) ? dres : 64'hBAD1_BAD1_BAD1_BAD1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf;
  } vec_t;

  vec_t tbl[10];

  task automatic apply_vec(input vec_t v);
    int          n;
    int          extra;
    bit          moved;
    logic [31:0] ua, ub;
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.funct       = v.funct;
    bus.rs_data     = v.a;
    bus.rt_data     = v.b;
    #1;
    chk("stall_idle", bus.stall, 0);
    chk("mf_data", bus.mf_data, v.mf);
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    bus.rs_data     = ~v.a;
    bus.rt_data     = ~v.b;
    chk("mul_sig_start", bus.mul_sig, (v.funct == F_MULTU) ? F_MULTU : 6'd0);
    chk("div_sig_start", bus.div_sig, (v.funct == F_DIVU && v.b != 0) ? F_DIVU : 6'd0);
    ua = bus.unit_a;
    ub = bus.unit_b;
    if (v.cyc != 0) begin
      chk("unit_a", ua, v.a);
      chk("unit_b", ub, v.b);
    end
    n = 0; extra = 0; moved = 1'b0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bus.mul_sig != 6'd0 || bus.div_sig != 6'd0) extra++;
      if (bus.unit_a != ua || bus.unit_b != ub) moved = 1'b1;
    end
    chk("busy_cycles", n, v.cyc);
    chk("sig_extra", extra, 0);
    chk("operands_held", moved, 0);
    chk("hi", bus.hi, v.hi);
    chk("lo", bus.lo, v.lo);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, bus.busy, 0);
  endtask

  initial begin
    int n;
    bit moved;
    bus.issue_valid = 1'b0;
    bus.funct       = '0;
    bus.rs_data     = '0;
    bus.rt_data     = '0;

    tbl[0] = '{F_MULTU, 32'h0000_FFFF, 32'h0001_0001, RUN_BUSY, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0};
    tbl[1] = '{F_MFLO,  32'h0,         32'h0,         0,        32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[2] = '{F_DIVU,  32'h1234_5678, 32'h0,         0,        32'h1234_5678, 32'hFFFF_FFFF, 32'h0};
    tbl[3] = '{F_MFHI,  32'h0,         32'h0,         0,        32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};
    tbl[4] = '{F_DIVU,  32'd1000,      32'd10,        RUN_BUSY, 32'd0,         32'd100,       32'h0};
    tbl[5] = '{F_MULT,  32'd5,         32'd5,         0,        32'd0,         32'd100,       32'h0};
    tbl[6] = '{F_DIVU,  32'hFFFF_FFFF, 32'd16,        RUN_BUSY, 32'h0000_000F, 32'h0FFF_FFFF, 32'h0};
    tbl[7] = '{F_ADDU,  32'd1,         32'd2,         0,        32'h0000_000F, 32'h0FFF_FFFF, 32'h0};
    tbl[8] = '{F_MULTU, 32'h0001_0000, 32'h0001_0000, RUN_BUSY, 32'h0000_0001, 32'h0000_0000, 32'h0};
    tbl[9] = '{F_MFHI,  32'h0,         32'h0,         0,        32'h0000_0001, 32'h0000_0000, 32'h0000_0001};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_mul_sig", bus.mul_sig, 0);
    chk("rst_div_sig", bus.div_sig, 0);
    chk("rst_unit_a", bus.unit_a, 0);
    chk("rst_unit_b", bus.unit_b, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) apply_vec(tbl[i]);

    // MFHI held right behind a MULTU: stalled for the full run, then reads new HI
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.funct       = F_MULTU;
    bus.rs_data     = 32'hFFFF_FFFF;
    bus.rt_data     = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.funct = F_MFHI;
    n = 0;
    while (bus.stall && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mfhi_stall_cycles", n, RUN_BUSY);
    chk("mfhi_after_run", bus.mf_data, 32'hFFFF_FFFE);
    chk("lo_after_ff_sq", bus.lo, 32'h0000_0001);
    bus.issue_valid = 1'b0;

    // DIVU with an MFLO that is withdrawn while stalled
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.funct       = F_DIVU;
    bus.rs_data     = 32'd100;
    bus.rt_data     = 32'd7;
    @(posedge clk); #1;
    chk("divu_sig", bus.div_sig, F_DIVU);
    bus.funct = F_MFLO;
    repeat (5) @(posedge clk);
    #1;
    chk("mflo_stalled", bus.stall, 1);
    bus.issue_valid = 1'b0;
    #1;
    chk("stall_dropped", bus.stall, 0);
    chk("run_continues", bus.busy, 1);
    wait_idle("divu_timeout");
    chk("divu_hi", bus.hi, 32'd2);
    chk("divu_lo", bus.lo, 32'd14);

    // Back-to-back MULTU: second held until IDLE, first result committed first
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.funct       = F_MULTU;
    bus.rs_data     = 32'd3;
    bus.rt_data     = 32'd5;
    @(posedge clk); #1;
    bus.rs_data = 32'd6;
    bus.rt_data = 32'd7;
    n = 0; moved = 1'b0;
    while (bus.stall && n < 200) begin
      if (bus.unit_a != 32'd3 || bus.unit_b != 32'd5) moved = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_stall_cycles", n, RUN_BUSY);
    chk("b2b_ops_held", moved, 0);
    chk("b2b_first_lo", bus.lo, 32'd15);
    chk("b2b_first_hi", bus.hi, 32'd0);
    @(posedge clk); #1;
    chk("b2b_second_start", bus.mul_sig, F_MULTU);
    chk("b2b_second_a", bus.unit_a, 32'd6);
    chk("b2b_second_b", bus.unit_b, 32'd7);
    bus.issue_valid = 1'b0;
    wait_idle("b2b_timeout");
    chk("b2b_second_lo", bus.lo, 32'd42);
    chk("b2b_second_hi", bus.hi, 32'd0);

    // Reset mid-run: result abandoned, stale unit output never committed
    @(negedge clk);
    bus.issue_valid = 1'b1;
    bus.funct       = F_MULTU;
    bus.rs_data     = 32'h0000_0010;
    bus.rt_data     = 32'h0000_0010;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    chk("midrst_unit_a", bus.unit_a, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("stale_hi", bus.hi, 0);
    chk("stale_lo", bus.lo, 0);
    chk("stale_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencing controller for the iterative multi-cycle multiplier and divider in the EX stage of the pipelined CPU. Accepts MULTU/DIVU/MFHI/MFLO from ID/EX and drives a one-cycle start opcode to the selected unit. Holds operands stable for the run, counts cycles, captures the 64-bit result into architectural HI/LO, and stalls the pipeline for any HI/LO-class instruction while a run is in flight.

Parameters:
MUL_CYCLES, 33, cycles from multiplier start until its dataOut is valid
DIV_CYCLES, 33, cycles from divider start until its dataOut is valid
F_MULTU, 6'b011001, funct code MULTU (25)
F_DIVU, 6'b011011, funct code DIVU (27)
F_MFHI, 6'b010000, funct code MFHI (16)
F_MFLO, 6'b010010, funct code MFLO (18)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
issue_valid  in  1  ID/EX holds a valid R-type instruction
funct  in  6  funct field of that instruction
rs_data  in  32  operand A (dividend / multiplicand)
rt_data  in  32  operand B (divisor / multiplier)
mul_sig  out  6  Signal to multiplier: F_MULTU for exactly one cycle per start, else 0
div_sig  out  6  Signal to divider: F_DIVU for exactly one cycle per start, else 0
unit_a  out  32  registered operand A to both units
unit_b  out  32  registered operand B to both units
mul_result  in  64  multiplier dataOut {hi,lo}
div_result  in  64  divider dataOut {remainder,quotient}
hi  out  32  architectural HI register
lo  out  32  architectural LO register
mf_data  out  32  MFHI -> hi, MFLO -> lo, else 0 (combinational)
busy  out  1  run in flight (state != IDLE)
stall  out  1  freeze IF/ID/EX this cycle (combinational)

Behaviour:
- Reset (rst=1 at edge): state=IDLE, cnt=0, hi=lo=0, unit_a=unit_b=0, mul_sig=div_sig=0. Any run in progress is abandoned; its result is never written.
- States: IDLE, MUL_RUN, DIV_RUN, CAPTURE. busy=1 in every state except IDLE.
- hl_op = issue_valid & funct in {MULTU,DIVU,MFHI,MFLO}.
- stall = hl_op & busy. Other functs never stall and are ignored.
- IDLE, MULTU at edge N:
  - unit_a<=rs_data, unit_b<=rt_data, cnt<=MUL_CYCLES, mul_sig<=F_MULTU, state<=MUL_RUN.
- IDLE, DIVU with rt_data!=0:
  - Same as MULTU, but using div_sig and DIV_CYCLES; state<=DIV_RUN.
- IDLE, DIVU with rt_data==0:
  - Divider not started; hi<=rs_data, lo<=32'hFFFFFFFF at that edge; state stays IDLE; busy stays 0.
- MUL_RUN/DIV_RUN:
  - mul_sig/div_sig return to 0 at the edge after start, so they are high for one cycle only.
  - cnt decrements each edge; at the edge where cnt==1, state<=CAPTURE.
- CAPTURE: at the next edge, {hi,lo}<=mul_result or div_result (per the unit started), state<=IDLE.
- Latency:
  - Start accepted at edge N; HI/LO updated at edge N+MUL_CYCLES+1.
  - busy=1 for cycles N..N+MUL_CYCLES+1.
  - Default: 34 busy cycles.
- unit_a/unit_b hold their value from the start edge until the next start; never changed mid-run.
- MFHI/MFLO in IDLE: no stall; mf_data is the current hi/lo.
- Request on the same cycle as CAPTURE: stalled. Next cycle sees IDLE and the new HI/LO (no same-cycle forwarding).
- Back-to-back MULTU: the second is stalled until IDLE, then accepted. The earlier result is committed before the new run starts.
- issue_valid dropping while stalled: nothing latched; the run continues unaffected.
- Units are unsigned only; signed MULT/DIV are not handled (ignored, no stall).

Test Plan:
- Reset, then MULTU rs=32'h0000_FFFF, rt=32'h0001_0001 at edge 0 -> mul_sig=6'b011001 for 1 cycle; busy 34 cycles; at edge 34 hi=32'h0000_0000, lo=32'h FFFF_FFFF; then MFLO gives mf_data=32'hFFFF_FFFF, stall=0.
- MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF, then MFHI presented immediately -> stall=1 for 34 cycles; next cycle mf_data=32'hFFFF_FFFE, lo=32'h0000_0001.
- DIVU rs=100, rt=7 -> div_sig pulses once; after 34 cycles hi=2, lo=14.
- DIVU rs=32'h1234_5678, rt=0 -> next edge hi=32'h1234_5678, lo=32'hFFFF_FFFF; busy never asserts; mul_sig=div_sig=0.
- MULTU started, rst=1 at run cycle 10 -> next edge state IDLE, hi=lo=0, busy=0; a later stale unit dataOut is never written into hi/lo.
- Two MULTUs back-to-back (3x5, then 6x7) -> second stalled until IDLE; hi/lo=15 then 42; unit_a/unit_b constant during each run.
